dvi_scanout_ctrl: RTL and testbench

- Parametrised successor to the fixed-XGA, 1-bit DVI controller.
- Generates all video timing from parameters and reads pixels from a double-buffered framebuffer with a configurable read latency.
- Expands 1, 16 or 24-bit pixels to RGB888 and emits the Chrontel 12-bit dual-edge words.
- The existing IOB/ODDR wrapper instantiates this block; it produces logic-level signals only.

---
 rtl/dvi_scanout_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dvi_scanout_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_scanout_ctrl.sv
// Parametrised DVI scanout: video timing, double-buffered framebuffer reads, RGB888 expansion.
// Defining DVI_TEST_PATTERN_EN adds a pattern_en input and an 8-bar colour generator.
module dvi_scanout_ctrl #(
    parameter int unsigned H_VISIBLE     = 1024,
    parameter int unsigned H_FRONT       = 24,
    parameter int unsigned H_SYNC        = 136,
    parameter int unsigned H_BACK        = 160,
    parameter int unsigned V_VISIBLE     = 768,
    parameter int unsigned V_FRONT       = 3,
    parameter int unsigned V_SYNC        = 6,
    parameter int unsigned V_BACK        = 29,
    parameter int unsigned SYNC_POLARITY = 0,
    parameter int unsigned PIX_W         = 16,
    parameter int unsigned FB_LATENCY    = 1,
    parameter int unsigned PIX_BITS      = $clog2(H_VISIBLE * V_VISIBLE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fb_sel,
`ifdef DVI_TEST_PATTERN_EN
    input  logic                pattern_en,
`endif
    output logic [PIX_BITS:0]   fb_addr,
    output logic                fb_rd_en,
    input  logic [PIX_W-1:0]    fb_data,
    output logic [11:0]         dvi_data_a,
    output logic [11:0]         dvi_data_b,
    output logic                dvi_de,
    output logic                dvi_h,
    output logic                dvi_v,
    output logic                frame_start,
    output logic                active_buf
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned L       = FB_LATENCY + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
    localparam logic [HW-1:0] H_VIS_S  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_VIS_E  = HW'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
    localparam logic [VW-1:0] V_VIS_S  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_VIS_E  = VW'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic          SYNC_ACT = (SYNC_POLARITY != 0);

    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [VW-1:0]       vcnt_q, vcnt_d;
    logic [PIX_BITS-1:0] pix_q, pix_d;
    logic                buf_q, buf_d;
    logic [L-1:0]        de_pipe_q, hs_pipe_q, vs_pipe_q, fs_pipe_q;
    logic [23:0]         rgb_q, rgb_d;
    logic [23:0]         fb_rgb, pix_rgb;
    logic                frame_top, visible, hs_lvl, vs_lvl, rd_ok;

    assign frame_top = (hcnt_q == '0) && (vcnt_q == '0);
    assign visible   = (hcnt_q >= H_VIS_S) && (hcnt_q < H_VIS_E) &&
                       (vcnt_q >= V_VIS_S) && (vcnt_q < V_VIS_E);
    assign hs_lvl    = (hcnt_q < H_SYNC_E) ? SYNC_ACT : ~SYNC_ACT;
    assign vs_lvl    = (vcnt_q < V_SYNC_E) ? SYNC_ACT : ~SYNC_ACT;

    if (PIX_W == 1) begin : g_mono
        assign fb_rgb = {24{fb_data[0]}};
    end else if (PIX_W == 16) begin : g_565
        assign fb_rgb = {fb_data[15:11], fb_data[15:13],
                         fb_data[10:5],  fb_data[10:9],
                         fb_data[4:0],   fb_data[4:2]};
    end else begin : g_888
        assign fb_rgb = fb_data[23:0];
    end

`ifdef DVI_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;
    localparam int unsigned BW    = $clog2(BAR_W + 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic                       pat_q, pat_d;
    logic [BW-1:0]              bar_x_q, bar_x_d;
    logic [2:0]                 bar_idx_q, bar_idx_d;
    logic [FB_LATENCY-1:0][2:0] bar_pipe_q;
    logic [2:0]                 bar;

    // Bar index travels with the pixel so it lines up with the data register.
    assign bar     = bar_pipe_q[FB_LATENCY-1];
    assign pix_rgb = pat_q ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : fb_rgb;
    assign rd_ok   = ~pat_q;

    always_comb begin
        pat_d     = frame_top ? pattern_en : pat_q;
        bar_x_d   = bar_x_q;
        bar_idx_d = bar_idx_q;
        if (hcnt_q == '0) begin
            bar_x_d   = '0;
            bar_idx_d = '0;
        end else if (visible) begin
            if (bar_x_q == BAR_LAST) begin
                bar_x_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                bar_x_d = bar_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q      <= 1'b0;
            bar_x_q    <= '0;
            bar_idx_q  <= '0;
            bar_pipe_q <= '0;
        end else begin
            pat_q      <= pat_d;
            bar_x_q    <= bar_x_d;
            bar_idx_q  <= bar_idx_d;
            for (int unsigned i = FB_LATENCY - 1; i > 0; i--) bar_pipe_q[i] <= bar_pipe_q[i-1];
            bar_pipe_q[0] <= bar_idx_q;
        end
    end
`else
    assign pix_rgb = fb_rgb;
    assign rd_ok   = 1'b1;
`endif

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
        pix_d = pix_q;
        buf_d = buf_q;
        if (frame_top) begin
            pix_d = '0;
            buf_d = fb_sel;
        end else if (visible) begin
            pix_d = pix_q + 1'b1;
        end
        // Stage L-2 holds the flags of the pixel whose fb_data is present this cycle.
        rgb_d = de_pipe_q[L-2] ? pix_rgb : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            pix_q     <= '0;
            buf_q     <= 1'b0;
            de_pipe_q <= '0;
            fs_pipe_q <= '0;
            hs_pipe_q <= {L{~SYNC_ACT}};
            vs_pipe_q <= {L{~SYNC_ACT}};
            rgb_q     <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            pix_q     <= pix_d;
            buf_q     <= buf_d;
            de_pipe_q <= {de_pipe_q[L-2:0], visible};
            fs_pipe_q <= {fs_pipe_q[L-2:0], frame_top};
            hs_pipe_q <= {hs_pipe_q[L-2:0], hs_lvl};
            vs_pipe_q <= {vs_pipe_q[L-2:0], vs_lvl};
            rgb_q     <= rgb_d;
        end
    end

    assign fb_addr     = {buf_q, pix_q};
    assign fb_rd_en    = visible & rd_ok;
    assign active_buf  = buf_q;
    assign dvi_de      = de_pipe_q[L-1];
    assign dvi_h       = hs_pipe_q[L-1];
    assign dvi_v       = vs_pipe_q[L-1];
    assign frame_start = fs_pipe_q[L-1];
    assign dvi_data_a  = rgb_q[11:0];
    assign dvi_data_b  = rgb_q[23:12];
endmodule

// File: tb/tb_dvi_scanout_ctrl.sv
// Scoreboard bench for dvi_scanout_ctrl on a tiny 15x8 raster with a 2-cycle framebuffer.
`timescale 1ns/1ps
module tb_dvi_scanout_ctrl;
    localparam int unsigned PB = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fb_sel;
`ifdef DVI_TEST_PATTERN_EN
    logic        pattern_en = 1'b0;
`endif
    logic [PB:0] fb_addr;
    logic        fb_rd_en;
    logic [15:0] fb_data;
    logic [11:0] dvi_data_a, dvi_data_b;
    logic        dvi_de, dvi_h, dvi_v, frame_start, active_buf;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    int first_fs, second_fs, first_vlow, vlow, hlow;
    int first_rd, first_rd_addr, first_de, run_len, f0_lines, bad_runs, blank_bad;
    int f0_cnt, f0_min, f0_max, f1_cnt, f1_min, f1_max;
    logic [23:0] sb_q[$];
    logic [PB:0] rd_a1, rd_a2;

    dvi_scanout_ctrl #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POLARITY(0), .PIX_W(16), .FB_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fb_sel(fb_sel),
`ifdef DVI_TEST_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
        .dvi_data_a(dvi_data_a), .dvi_data_b(dvi_data_b),
        .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v),
        .frame_start(frame_start), .active_buf(active_buf)
    );

    always #5 clk = ~clk;

    // Framebuffer contents: a few directed words, otherwise the address itself.
    function automatic logic [15:0] mem_word(input logic [PB:0] a);
        case (a)
            6'd0:    return 16'hF800;
            6'd1:    return 16'h07E0;
            6'd2:    return 16'h001F;
            6'd3:    return 16'hFFFF;
            6'd4:    return 16'h8410;
            default: return {10'b0, a};
        endcase
    endfunction

    // Expected {dvi_data_b, dvi_data_a} for a read of address a.
    function automatic logic [23:0] exp_word(input logic [PB:0] a);
        logic [15:0] w;
        int r5, g6, b5;
        logic [7:0] r8, g8, b8;
        case (a)
            6'd0: return {12'hFF0, 12'h000};
            6'd1: return {12'h00F, 12'hF00};
            6'd2: return {12'h000, 12'h0FF};
            6'd3: return {12'hFFF, 12'hFFF};
            6'd4: return {12'h848, 12'h284};
            default: begin
                w  = {10'b0, a};
                r5 = int'(w[15:11]);
                g6 = int'(w[10:5]);
                b5 = int'(w[4:0]);
                r8 = 8'(r5 * 8 + r5 / 4);
                g8 = 8'(g6 * 4 + g6 / 16);
                b8 = 8'(b5 * 8 + b5 / 4);
                return {r8, g8[7:4], g8[3:0], b8};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        rd_a1 <= fb_addr;
        rd_a2 <= rd_a1;
    end
    assign fb_data = mem_word(rd_a2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        first_fs = -1; second_fs = -1; first_vlow = -1; vlow = 0; hlow = 0;
        first_rd = -1; first_rd_addr = -1; first_de = -1; run_len = 0;
        f0_lines = 0; bad_runs = 0; blank_bad = 0;
        f0_cnt = 0; f0_min = 999; f0_max = -1;
        f1_cnt = 0; f1_min = 999; f1_max = -1;
    endtask

    // Monitor: records timing, pushes on reads, pops and compares on data enable.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            clear_stats();
        end else begin
            if (frame_start) begin
                if (first_fs < 0)       first_fs = cyc;
                else if (second_fs < 0) second_fs = cyc;
            end
            if (cyc < 123) begin
                if (!dvi_v) vlow++;
                if (!dvi_h) hlow++;
                if (!dvi_v && first_vlow < 0) first_vlow = cyc;
            end
            if (fb_rd_en) begin
                if (first_rd < 0) begin
                    first_rd      = cyc;
                    first_rd_addr = int'(fb_addr);
                end
                if (cyc < 120) begin
                    f0_cnt++;
                    if (int'(fb_addr) < f0_min) f0_min = int'(fb_addr);
                    if (int'(fb_addr) > f0_max) f0_max = int'(fb_addr);
                end else if (cyc < 240) begin
                    f1_cnt++;
                    if (int'(fb_addr) < f1_min) f1_min = int'(fb_addr);
                    if (int'(fb_addr) > f1_max) f1_max = int'(fb_addr);
                end
                sb_q.push_back(exp_word(fb_addr));
            end
            if (dvi_de) begin
                if (first_de < 0) first_de = cyc;
                run_len++;
                check("sb_avail", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) check("pixel", {8'h0, dvi_data_b, dvi_data_a}, {8'h0, sb_q.pop_front()});
            end else begin
                if (run_len != 0) begin
                    if (cyc < 123) f0_lines++;
                    if (run_len != 8) bad_runs++;
                    run_len = 0;
                end
                if (dvi_data_a != 12'h0 || dvi_data_b != 12'h0) blank_bad++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_fb_addr"}, 32'(fb_addr), 0);
        check({tag, "_fb_rd_en"}, 32'(fb_rd_en), 0);
        check({tag, "_de"}, 32'(dvi_de), 0);
        check({tag, "_data"}, {8'h0, dvi_data_b, dvi_data_a}, 0);
        check({tag, "_h"}, 32'(dvi_h), 1);
        check({tag, "_v"}, 32'(dvi_v), 1);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_buf"}, 32'(active_buf), 0);
    endtask

    task automatic check_stats(input int base, input bit second_frame);
        check("first_fs", first_fs, 3);
        check("frame_period", second_fs - first_fs, 120);
        check("first_vlow", first_vlow, 3);
        check("vsync_len", vlow, 30);
        check("hsync_total", hlow, 24);
        check("first_rd_cycle", first_rd, 50);
        check("first_rd_addr", first_rd_addr, base);
        check("first_de_cycle", first_de, 53);
        check("de_lines", f0_lines, 4);
        check("de_bad_runs", bad_runs, 0);
        check("blank_data", blank_bad, 0);
        check("f0_reads", f0_cnt, 32);
        check("f0_min", f0_min, base);
        check("f0_max", f0_max, base + 31);
        if (second_frame) begin
            check("f1_reads", f1_cnt, 32);
            check("f1_min", f1_min, 32);
            check("f1_max", f1_max, 63);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        fb_sel = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("init");
        #1 rst_n = 1'b1;

        wait_cyc(60);
        fb_sel = 1'b1;
        wait_cyc(65);
        check("buf_hold", 32'(active_buf), 0);
        check("addr_msb_hold", 32'(fb_addr[PB]), 0);
        wait_cyc(125);
        check("buf_next_frame", 32'(active_buf), 1);
        wait_cyc(250);
        check_stats(0, 1'b1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(130);
        check_stats(32, 1'b0);
        check("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
